thread_regfile: RTL and testbench

Parametrised per-thread register file for the SIMD compute core, successor to the fixed 16 x 8-bit thread register file. Register count and data width are configurable, and three read-only registers always hold %blockIdx, %blockDim and %threadIdx. A per-register pending scoreboard lets LDR results return asynchronously from the LSU on a dedicated write port. A registered hazard flag tells the scheduler when an operand or destination is still waiting on a load.

---
 rtl/thread_regfile_if.sv | 38 +++
 rtl/thread_regfile.sv | 96 +++++++++
 tb/tb_thread_regfile.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/thread_regfile_if.sv
// Instruction, load-return and operand bus between the thread scheduler/LSU and thread_regfile.
// The master side drives decoded fields and load returns; the slave side returns operands.
interface thread_regfile_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned NUM_REGS  = 16
);
  localparam int unsigned ADDR_BITS = $clog2(NUM_REGS);

  logic [2:0]           core_state;
  logic [ADDR_BITS-1:0] decoded_rd_address;
  logic [ADDR_BITS-1:0] decoded_rs_address;
  logic [ADDR_BITS-1:0] decoded_rt_address;
  logic                 decoded_reg_write_enable;
  logic [1:0]           decoded_reg_input_mux;
  logic [DATA_BITS-1:0] decoded_immediate;
  logic [DATA_BITS-1:0] alu_out;
  logic                 ld_ret_valid;
  logic [ADDR_BITS-1:0] ld_ret_addr;
  logic [DATA_BITS-1:0] ld_ret_data;
  logic [DATA_BITS-1:0] rs;
  logic [DATA_BITS-1:0] rt;
  logic                 hazard;
  logic [NUM_REGS-1:0]  pending_mask;

  modport master (
    output core_state, decoded_rd_address, decoded_rs_address, decoded_rt_address,
           decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate, alu_out,
           ld_ret_valid, ld_ret_addr, ld_ret_data,
    input  rs, rt, hazard, pending_mask
  );

  modport slave (
    input  core_state, decoded_rd_address, decoded_rs_address, decoded_rt_address,
           decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate, alu_out,
           ld_ret_valid, ld_ret_addr, ld_ret_data,
    output rs, rt, hazard, pending_mask
  );
endinterface

// File: rtl/thread_regfile.sv
// Per-thread register file with read-only block/thread registers and a load-pending scoreboard.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle load returns into operand reads.
module thread_regfile #(
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned THREAD_ID         = 0,
  parameter int unsigned DATA_BITS         = 8,
  parameter int unsigned NUM_REGS          = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [7:0]          block_id,
  thread_regfile_if.slave     bus
);
  localparam int unsigned ADDR_BITS = $clog2(NUM_REGS);

  localparam logic [2:0] CoreRequest = 3'b011;
  localparam logic [2:0] CoreUpdate  = 3'b110;

  localparam logic [ADDR_BITS-1:0] RoBase        = ADDR_BITS'(NUM_REGS - 3);
  localparam logic [ADDR_BITS-1:0] BlockDimAddr  = ADDR_BITS'(NUM_REGS - 2);
  localparam logic [ADDR_BITS-1:0] ThreadIdxAddr = ADDR_BITS'(NUM_REGS - 1);

  logic [DATA_BITS-1:0] regs_q [NUM_REGS];
  logic [DATA_BITS-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]  pend_q, pend_d, pend_view;
  logic [DATA_BITS-1:0] rs_q, rs_d, rt_q, rt_d;
  logic                 hazard_q, hazard_d;
  logic                 ret_ok, upd_ok, is_request;

  assign ret_ok     = bus.ld_ret_valid && (bus.ld_ret_addr < RoBase);
  assign upd_ok     = (bus.core_state == CoreUpdate) && bus.decoded_reg_write_enable &&
                      (bus.decoded_rd_address < RoBase);
  assign is_request = (bus.core_state == CoreRequest);

  // Return is applied first so a same-cycle UPDATE to the same register overrides it.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (ret_ok) begin
      regs_d[bus.ld_ret_addr] = bus.ld_ret_data;
      pend_d[bus.ld_ret_addr] = 1'b0;
    end
    if (upd_ok) begin
      unique case (bus.decoded_reg_input_mux)
        2'b00:   regs_d[bus.decoded_rd_address] = bus.alu_out;
        2'b10:   regs_d[bus.decoded_rd_address] = bus.decoded_immediate;
        2'b01:   pend_d[bus.decoded_rd_address] = 1'b1;
        default: ;
      endcase
    end
    regs_d[RoBase] = DATA_BITS'(block_id);
  end

  always_comb begin
    pend_view = pend_q;
    rs_d      = regs_q[bus.decoded_rs_address];
    rt_d      = regs_q[bus.decoded_rt_address];
`ifdef REGFILE_BYPASS_EN
    if (ret_ok) begin
      pend_view[bus.ld_ret_addr] = 1'b0;
      if (bus.ld_ret_addr == bus.decoded_rs_address) rs_d = bus.ld_ret_data;
      if (bus.ld_ret_addr == bus.decoded_rt_address) rt_d = bus.ld_ret_data;
    end
`endif
    hazard_d = pend_view[bus.decoded_rs_address] | pend_view[bus.decoded_rt_address] |
               (bus.decoded_reg_write_enable & pend_view[bus.decoded_rd_address]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[ADDR_BITS'(i)] <= '0;
      end
      regs_q[BlockDimAddr]  <= DATA_BITS'(THREADS_PER_BLOCK);
      regs_q[ThreadIdxAddr] <= DATA_BITS'(THREAD_ID);
      pend_q   <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      hazard_q <= 1'b0;
    end else if (enable) begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      if (is_request) begin
        rs_q     <= rs_d;
        rt_q     <= rt_d;
        hazard_q <= hazard_d;
      end
    end
  end

  assign bus.rs           = rs_q;
  assign bus.rt           = rt_q;
  assign bus.hazard       = hazard_q;
  assign bus.pending_mask = pend_q;
endmodule

// File: tb/tb_thread_regfile.sv
// Self-checking bench for thread_regfile: directed scenarios plus randomized traffic against
// a register-file model built from the architectural rules.
module tb_thread_regfile;
  localparam int unsigned NR  = 16;
  localparam int unsigned RO  = NR - 3;
  localparam logic [2:0] REQ = 3'b011;
  localparam logic [2:0] UPD = 3'b110;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] block_id;

  int checks = 0;
  int errors = 0;

  thread_regfile_if #(.DATA_BITS(8), .NUM_REGS(NR)) bus ();

  thread_regfile #(
    .THREADS_PER_BLOCK(4),
    .THREAD_ID(2),
    .DATA_BITS(8),
    .NUM_REGS(NR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .block_id(block_id),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Architectural state of one thread
  logic [7:0]  m_regs [NR];
  logic [15:0] m_pend;
  logic [7:0]  m_rs, m_rt;
  logic        m_haz;

  task automatic model_step();
    logic [7:0]  view_regs [NR];
    logic [15:0] view_pend;
    logic        ret_hit;
    int          rd, rs, rt, ra;
    rd = int'(bus.decoded_rd_address);
    rs = int'(bus.decoded_rs_address);
    rt = int'(bus.decoded_rt_address);
    ra = int'(bus.ld_ret_addr);
    if (reset) begin
      for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
      m_regs[RO + 1] = 8'd4;
      m_regs[RO + 2] = 8'd2;
      m_pend = '0;
      m_rs = '0;
      m_rt = '0;
      m_haz = 1'b0;
    end else if (enable) begin
      ret_hit = bus.ld_ret_valid && (ra < RO);
      if (bus.core_state == REQ) begin
        view_regs = m_regs;
        view_pend = m_pend;
`ifdef REGFILE_BYPASS_EN
        if (ret_hit) begin
          view_regs[ra] = bus.ld_ret_data;
          view_pend[ra] = 1'b0;
        end
`endif
        m_rs  = view_regs[rs];
        m_rt  = view_regs[rt];
        m_haz = view_pend[rs] | view_pend[rt] | (bus.decoded_reg_write_enable & view_pend[rd]);
      end
      if (ret_hit) begin
        m_regs[ra] = bus.ld_ret_data;
        m_pend[ra] = 1'b0;
      end
      if (bus.core_state == UPD && bus.decoded_reg_write_enable && rd < RO) begin
        case (bus.decoded_reg_input_mux)
          2'b00: m_regs[rd] = bus.alu_out;
          2'b10: m_regs[rd] = bus.decoded_immediate;
          2'b01: m_pend[rd] = 1'b1;
          default: ;
        endcase
      end
      m_regs[RO] = block_id;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".rs"}, 32'(bus.rs), 32'(m_rs));
    check({tag, ".rt"}, 32'(bus.rt), 32'(m_rt));
    check({tag, ".hazard"}, 32'(bus.hazard), 32'(m_haz));
    check({tag, ".pending"}, 32'(bus.pending_mask), 32'(m_pend));
  endtask

  task automatic idle();
    bus.core_state               = 3'b000;
    bus.decoded_rd_address       = '0;
    bus.decoded_rs_address       = '0;
    bus.decoded_rt_address       = '0;
    bus.decoded_reg_write_enable = 1'b0;
    bus.decoded_reg_input_mux    = 2'b11;
    bus.decoded_immediate        = '0;
    bus.alu_out                  = '0;
    bus.ld_ret_valid             = 1'b0;
    bus.ld_ret_addr              = '0;
    bus.ld_ret_data              = '0;
  endtask

  task automatic req(input int rs, input int rt);
    idle();
    bus.core_state         = REQ;
    bus.decoded_rs_address = 4'(rs);
    bus.decoded_rt_address = 4'(rt);
  endtask

  task automatic upd(input int rd, input logic [1:0] mux, input logic [7:0] val);
    idle();
    bus.core_state               = UPD;
    bus.decoded_rd_address       = 4'(rd);
    bus.decoded_reg_write_enable = 1'b1;
    bus.decoded_reg_input_mux    = mux;
    bus.decoded_immediate        = val;
    bus.alu_out                  = val;
  endtask

  task automatic ret(input int addr, input logic [7:0] data);
    bus.ld_ret_valid = 1'b1;
    bus.ld_ret_addr  = 4'(addr);
    bus.ld_ret_data  = data;
  endtask

  initial begin
    int r;
    idle();
    reset    = 1'b1;
    enable   = 1'b1;
    block_id = 8'd5;
    tick("reset0");
    tick("reset1");
    check("reset_rs_zero", 32'(bus.rs), 32'h0);
    check("reset_pending_zero", 32'(bus.pending_mask), 32'h0);
    reset = 1'b0;

    idle();
    tick("blockidx_load");
    req(13, 15);
    tick("read_ro");
    check("blockIdx", 32'(bus.rs), 32'h05);
    check("threadIdx", 32'(bus.rt), 32'h02);

    upd(3, 2'b10, 8'hA5);
    tick("const_rd3");
    req(3, 14);
    tick("read_rd3");
    check("const_write", 32'(bus.rs), 32'hA5);
    upd(14, 2'b10, 8'h77);
    tick("const_ro14");
    req(14, 3);
    tick("read_ro14");
    check("ro_write_ignored", 32'(bus.rs), 32'h04);

    upd(4, 2'b01, 8'h00);
    tick("ldr_rd4");
    check("pending_set", 32'(bus.pending_mask), 32'h0010);
    req(4, 0);
    tick("req_pending");
    check("hazard_on_pending", 32'(bus.hazard), 32'h1);
    idle();
    ret(4, 8'h3C);
    tick("ret_rd4");
    check("pending_cleared", 32'(bus.pending_mask), 32'h0000);
    req(4, 0);
    tick("read_ret");
    check("ret_data", 32'(bus.rs), 32'h3C);
    check("ret_no_hazard", 32'(bus.hazard), 32'h0);

    upd(4, 2'b01, 8'h00);
    tick("ldr_rd4_again");
    req(4, 0);
    ret(4, 8'h11);
    tick("req_with_ret");
`ifdef REGFILE_BYPASS_EN
    check("bypass_data", 32'(bus.rs), 32'h11);
    check("bypass_hazard", 32'(bus.hazard), 32'h0);
`else
    check("stale_data", 32'(bus.rs), 32'h3C);
    check("stale_hazard", 32'(bus.hazard), 32'h1);
`endif
    check("req_ret_pending", 32'(bus.pending_mask), 32'h0);

    upd(6, 2'b00, 8'h20);
    ret(6, 8'h99);
    tick("alu_vs_ret");
    check("alu_vs_ret_pending", 32'(bus.pending_mask), 32'h0);
    req(6, 4);
    tick("read_rd6");
    check("alu_wins", 32'(bus.rs), 32'h20);
    check("ret_rd4_written", 32'(bus.rt), 32'h11);

    upd(8, 2'b01, 8'h00);
    ret(8, 8'h5A);
    tick("ldr_vs_ret");
    check("ldr_vs_ret_pending", 32'(bus.pending_mask), 32'h0100);
    idle();
    ret(8, 8'h6B);
    tick("ret_rd8");

    enable = 1'b0;
    upd(2, 2'b10, 8'h55);
    ret(5, 8'h66);
    tick("disabled");
    enable = 1'b1;
    req(2, 5);
    tick("read_after_disable");
    check("disabled_rd2", 32'(bus.rs), 32'h00);
    check("disabled_rd5", 32'(bus.rt), 32'h00);

    upd(7, 2'b01, 8'h00);
    tick("ldr_rd7");
    check("pending_rd7", 32'(bus.pending_mask), 32'h0080);
    reset = 1'b1;
    idle();
    tick("mid_reset");
    check("mid_reset_pending", 32'(bus.pending_mask), 32'h0);
    check("mid_reset_rs", 32'(bus.rs), 32'h0);
    check("mid_reset_rt", 32'(bus.rt), 32'h0);
    reset = 1'b0;

    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 3));
      bus.core_state = (r == 0) ? REQ : (r == 1) ? UPD : 3'($urandom);
      bus.decoded_rd_address       = 4'($urandom);
      bus.decoded_rs_address       = 4'($urandom);
      bus.decoded_rt_address       = 4'($urandom);
      bus.decoded_reg_write_enable = 1'($urandom);
      bus.decoded_reg_input_mux    = 2'($urandom);
      bus.decoded_immediate        = 8'($urandom);
      bus.alu_out                  = 8'($urandom);
      bus.ld_ret_valid             = ($urandom_range(0, 2) == 0);
      bus.ld_ret_addr              = 4'($urandom);
      bus.ld_ret_data              = 8'($urandom);
      block_id = 8'($urandom);
      enable   = ($urandom_range(0, 9) != 0);
      reset    = ($urandom_range(0, 99) == 0);
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
